// File: rtl/mips_dmem_ws_pkg.sv
// Shared definitions for the wait-stated MIPS data memory: the FSM state
// encoding, the wait counter width, and helpers that derive the byte-lane
// count and the byte-offset width from the data word width.
package mips_dmem_ws_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Wide enough for the largest legal wait-state count (15).
  localparam int CNT_W = 4;

  // Number of byte lanes in one data word.
  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Number of low address bits that select a byte within a word.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mips_ws_counter.sv
// Loadable down-counter used as the wait-state timer. tc flags the last
// wait cycle, i.e. the cycle in which the counter holds 1.
module mips_ws_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == W'(1));

endmodule

// File: rtl/mips_dmem_ws.sv
// Word-organised data memory with a fixed number of wait states per access.
// One access is in flight at a time; requests arriving while busy are
// dropped. Illegal accesses (misaligned or beyond DEPTH) take the normal
// latency but only raise err, never touching storage.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | ready=1, waiting for req
//   WAIT    | request captured, wait-state counter running
//   RESP    | done pulse; read data presented, write committed at exit
module mips_dmem_ws
  import mips_dmem_ws_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2,
  parameter int TEST_CH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [31:0]           addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  err,
  output logic [16*TEST_CH-1:0] test_value
);

  localparam int LANES = byte_lanes(DATA_W);
  localparam int OFF   = off_w(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              accept;

  logic [31:0]       word_full;
  logic              addr_bad;

  logic              req_we;
  logic [LANES-1:0]  req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [IDX_W-1:0]  req_idx;
  logic              req_bad;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_tc;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept = (state == ST_IDLE) && req;

  // Legality is resolved at capture so the response path only needs a flag.
  assign word_full = addr >> OFF;
  assign addr_bad  = (addr[OFF-1:0] != '0) || (word_full >= 32'(DEPTH));

  mips_ws_counter #(
    .W (CNT_W)
  ) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CNT_W'(WAIT_CYC)),
    .dec      (state == ST_WAIT),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  // Next-state logic; zero wait states skip WAIT entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (req) begin
          state_nxt = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_tc) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request capture on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_we    <= 1'b0;
      req_be    <= '0;
      req_wdata <= '0;
      req_idx   <= '0;
      req_bad   <= 1'b0;
    end else if (accept) begin
      req_we    <= we;
      req_be    <= be;
      req_wdata <= wdata;
      req_idx   <= word_full[IDX_W-1:0];
      req_bad   <= addr_bad;
    end
  end

  // Storage; a legal write commits its enabled lanes on the edge leaving RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if ((state == ST_RESP) && req_we && !req_bad) begin
      for (int b = 0; b < LANES; b++) begin
        if (req_be[b]) begin
          mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_RESP);
  assign err   = done && req_bad;

  // Storage cannot change between capture and RESP, so a direct read here
  // returns the word as it stood on entry to RESP.
  assign rdata = (done && !req_we && !req_bad) ? mem[req_idx] : '0;

  // Low half-word of each of the first TEST_CH words.
  for (genvar k = 0; k < TEST_CH; k++) begin : g_test
    assign test_value[16*k +: 16] = mem[k][15:0];
  end

endmodule

// File: tb/tb_mips_dmem_ws.sv
// Self-checking bench for mips_dmem_ws. A transaction-level model tracks
// the accepted request, its completion cycle (acceptance edge + WAIT_CYC)
// and the memory image; every falling edge compares the DUT with it.
module tb_mips_dmem_ws;

  localparam int W = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [63:0] test_value;

  logic        req0;
  logic        ready0;
  logic        done0;
  logic [31:0] rdata0;
  logic        err0;
  logic [15:0] tv0;

  int checks;
  int errors;

  mips_dmem_ws #(
    .DATA_W   (32),
    .DEPTH    (64),
    .WAIT_CYC (W),
    .TEST_CH  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .be         (be),
    .addr       (addr),
    .wdata      (wdata),
    .ready      (ready),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .test_value (test_value)
  );

  mips_dmem_ws #(
    .DATA_W   (32),
    .DEPTH    (64),
    .WAIT_CYC (0),
    .TEST_CH  (1)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req        (req0),
    .we         (1'b0),
    .be         (4'h0),
    .addr       (32'h0),
    .wdata      (32'h0),
    .ready      (ready0),
    .done       (done0),
    .rdata      (rdata0),
    .err        (err0),
    .test_value (tv0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_m [64];
  int          ecnt;
  int          m_acc;
  logic        m_busy;
  logic        m_we;
  logic [3:0]  m_be;
  logic [31:0] m_wd;
  logic        m_legal;
  logic [5:0]  m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecnt    <= 0;
      m_acc   <= 0;
      m_busy  <= 1'b0;
      m_we    <= 1'b0;
      m_be    <= '0;
      m_wd    <= '0;
      m_legal <= 1'b0;
      m_idx   <= '0;
      for (int i = 0; i < 64; i++) mem_m[i] <= '0;
    end else begin
      ecnt <= ecnt + 1;
      if (m_busy) begin
        if (ecnt == m_acc + W) begin
          if (m_we && m_legal)
            for (int b = 0; b < 4; b++)
              if (m_be[b]) mem_m[m_idx][8*b +: 8] <= m_wd[8*b +: 8];
          m_busy <= 1'b0;
        end
      end else if (req) begin
        m_busy  <= 1'b1;
        m_acc   <= ecnt + 1;
        m_we    <= we;
        m_be    <= be;
        m_wd    <= wdata;
        m_legal <= ((addr % 4) == 0) && ((addr / 4) < 64);
        m_idx   <= 6'(addr / 4);
      end
    end
  end

  logic        exp_ready;
  logic        exp_done;
  logic        exp_err;
  logic [31:0] exp_rdata;
  logic [63:0] exp_tv;

  assign exp_ready = !m_busy;
  assign exp_done  = m_busy && (ecnt == m_acc + W);
  assign exp_err   = exp_done && !m_legal;
  assign exp_rdata = (exp_done && !m_we && m_legal) ? mem_m[m_idx] : 32'h0;
  assign exp_tv    = {mem_m[3][15:0], mem_m[2][15:0], mem_m[1][15:0], mem_m[0][15:0]};

  always @(negedge clk) begin
    chk("ready", 64'(ready), 64'(exp_ready));
    chk("done", 64'(done), 64'(exp_done));
    chk("err", 64'(err), 64'(exp_err));
    chk("rdata", 64'(rdata), 64'(exp_rdata));
    chk("test_value", test_value, exp_tv);
  end

  // ---------------- driver ----------------
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_lat;

  task automatic access(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d);
    int n;
    @(negedge clk);
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    last_lat = 99;
    last_rdata = 32'hx;
    last_err = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        last_lat   = i;
        last_rdata = rdata;
        last_err   = err;
        req = 1'b0;
        break;
      end
      // Junk while busy must be ignored.
      req   = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      be    = 4'($urandom);
      addr  = $urandom;
      wdata = $urandom;
    end
    req = 1'b0;
    chk("latency", 64'(last_lat), 64'(W + 1));
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      1:       return 32'h100 + 32'($urandom_range(0, 255) * 4);
      2:       return $urandom;
      default: return 32'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  initial begin
    bit seen_done;
    bit prev;
    int cnt0;
    checks = 0;
    errors = 0;
    rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; req0 = 1'b0;
    #22;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_tv", test_value, 64'd0);
    rst = 1'b0;
    req0 = 1'b1;

    access(1'b1, 4'hF, 32'h8, 32'hDEADBEEF);
    chk("wr8_err", 64'(last_err), 64'd0);
    chk("wr8_lat", 64'(last_lat), 64'd3);
    access(1'b0, 4'h0, 32'h8, 32'h0);
    chk("rd8", 64'(last_rdata), 64'hDEADBEEF);

    access(1'b1, 4'hF, 32'h0, 32'h12345678);
    access(1'b1, 4'b0001, 32'h0, 32'h000000AA);
    access(1'b0, 4'h0, 32'h0, 32'h0);
    chk("rd0_be", 64'(last_rdata), 64'h123456AA);
    chk("tv0_be", 64'(test_value[15:0]), 64'h56AA);

    access(1'b0, 4'h0, 32'h102, 32'h0);
    chk("mis_err", 64'(last_err), 64'd1);
    chk("mis_rdata", 64'(last_rdata), 64'd0);
    access(1'b1, 4'hF, 32'h100, 32'h0BADF00D);
    chk("oor_wr_err", 64'(last_err), 64'd1);
    access(1'b0, 4'h0, 32'h100, 32'h0);
    chk("oor_err", 64'(last_err), 64'd1);
    chk("oor_rdata", 64'(last_rdata), 64'd0);
    access(1'b1, 4'h0, 32'h8, 32'h11111111);
    chk("be0_err", 64'(last_err), 64'd0);
    access(1'b0, 4'h0, 32'h8, 32'h0);
    chk("unchanged8", 64'(last_rdata), 64'hDEADBEEF);

    for (int t = 0; t < 150; t++)
      access(1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom);

    for (int k = 0; k < 4; k++) access(1'b1, 4'hF, 32'(4 * k), 32'(k + 1));
    @(negedge clk);
    chk("tv_4ch", test_value, 64'h0004_0003_0002_0001);

    // Zero-wait instance with req held high: one completion every 2 cycles.
    cnt0 = 0;
    prev = done0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("ws0_alt", 64'(done0), 64'(!prev));
      chk("ws0_ready", 64'(ready0), 64'(!done0));
      prev = done0;
      if (done0) cnt0++;
    end
    chk("ws0_count", 64'(cnt0), 64'd10);

    // Reset in the middle of a write to word 2.
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'hCAFE0002;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    chk("abort_busy", 64'(ready), 64'd0);
    #2 rst = 1'b1;
    seen_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 64'(seen_done), 64'd0);
    access(1'b0, 4'h0, 32'h8, 32'h0);
    chk("abort_word2", 64'(last_rdata), 64'd0);
    chk("abort_tv", test_value, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
